time_counter: RTL

BCD time-of-day counter that consumes the divider chain's 1 Hz square-wave output and maintains hours/minutes/seconds. It runs on the system clock `clk`, synchronizes and edge-detects the 1 Hz level, and advances the time once per rising edge. A three-state mode machine driven by two user keys lets the user set hours and minutes. Outputs feed the display-scan stage and any alarm/compare logic.

---
 rtl/time_counter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/time_counter.sv
// time_counter: BCD hours/minutes/seconds counter advanced by a synchronized 1 Hz input,
// with key-driven hour/minute setting. Define TIME_COUNTER_12H_EN for 12-hour mode with PM flag.
module time_counter #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sec_in,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       pm,
    output logic [1:0] set_state,
    output logic       sec_tick,
    output logic       day_tick
);
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } mode_e;

`ifdef TIME_COUNTER_12H_EN
    localparam logic [7:0] HOUR_RST = 8'h12;
`else
    localparam logic [7:0] HOUR_RST = 8'h00;
`endif

    logic [2:0] async_in;
    logic [2:0] sync_q [SYNC_STAGES];
    logic [2:0] edge_q;
    logic [2:0] synced;
    logic [2:0] ev;
    logic       sec_ev, mode_ev, inc_ev;

    mode_e      state_q;
    logic [7:0] hour_q, min_q, sec_q;
    logic       pm_q, sec_tick_q, day_tick_q;

    logic [7:0] sec_nxt, min_nxt, hour_nxt;
    logic       sec_wrap, min_wrap, pm_flip, day_wrap;

    // Bit order {inc, mode, sec} shared by synchronizer, edge flops and strobes.
    assign async_in = {key_inc, key_mode, sec_in};
    assign synced   = sync_q[SYNC_STAGES-1];
    assign ev       = synced & ~edge_q;
    assign sec_ev   = ev[0];
    assign mode_ev  = ev[1];
    assign inc_ev   = ev[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            edge_q <= '0;
        end else begin
            sync_q[0] <= async_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            edge_q <= synced;
        end
    end

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign sec_wrap = (sec_q == 8'h59);
    assign min_wrap = (min_q == 8'h59);
    assign sec_nxt  = sec_wrap ? 8'h00 : bcd_inc(sec_q);
    assign min_nxt  = min_wrap ? 8'h00 : bcd_inc(min_q);

`ifdef TIME_COUNTER_12H_EN
    // 12 is followed by 01; 11 -> 12 crosses noon/midnight and flips the PM flag.
    assign hour_nxt = (hour_q == 8'h12) ? 8'h01 : bcd_inc(hour_q);
    assign pm_flip  = (hour_q == 8'h11);
    assign day_wrap = pm_flip & pm_q;
`else
    assign hour_nxt = (hour_q == 8'h23) ? 8'h00 : bcd_inc(hour_q);
    assign pm_flip  = 1'b0;
    assign day_wrap = (hour_q == 8'h23);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            hour_q     <= HOUR_RST;
            min_q      <= '0;
            sec_q      <= '0;
            pm_q       <= 1'b0;
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
        end else begin
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
            if (mode_ev) begin
                // Mode change wins; coincident second/increment strobes are dropped.
                case (state_q)
                    RUN: begin
                        state_q <= SET_HOUR;
                        sec_q   <= '0;
                    end
                    SET_HOUR: state_q <= SET_MIN;
                    default:  state_q <= RUN;
                endcase
            end else begin
                case (state_q)
                    RUN: begin
                        if (sec_ev) begin
                            sec_tick_q <= 1'b1;
                            sec_q      <= sec_nxt;
                            if (sec_wrap) begin
                                min_q <= min_nxt;
                                if (min_wrap) begin
                                    hour_q     <= hour_nxt;
                                    day_tick_q <= day_wrap;
                                    if (pm_flip) begin
                                        pm_q <= ~pm_q;
                                    end
                                end
                            end
                        end
                    end
                    SET_HOUR: begin
                        if (inc_ev) begin
                            hour_q <= hour_nxt;
                            if (pm_flip) begin
                                pm_q <= ~pm_q;
                            end
                        end
                    end
                    SET_MIN: begin
                        if (inc_ev) begin
                            min_q <= min_nxt;
                        end
                    end
                    default: state_q <= RUN;
                endcase
            end
        end
    end

    assign hour_bcd  = hour_q;
    assign min_bcd   = min_q;
    assign sec_bcd   = sec_q;
    assign pm        = pm_q;
    assign set_state = state_q;
    assign sec_tick  = sec_tick_q;
    assign day_tick  = day_tick_q;

endmodule
